divisor_secuencial: RTL and testbench

//  Sequential unsigned integer divider. It is the inverse companion of the

---
 rtl/divisor_secuencial.sv | 125 ++++++++++++
 tb/tb_divisor_secuencial.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: unsigned restoring shift-subtract divider producing one
// quotient bit per clock behind a start/busy/done handshake.
// Operand, quotient and remainder width is W = SAMPLES*OSF.
module divisor_secuencial #(
    parameter int SAMPLES = 1,
    parameter int OSF     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SAMPLES*OSF-1:0] A,
    input  logic [SAMPLES*OSF-1:0] B,
    output logic                   busy,
    output logic                   done,
    output logic [SAMPLES*OSF-1:0] Q,
    output logic [SAMPLES*OSF-1:0] R,
    output logic                   div_zero
);

    localparam int W  = SAMPLES * OSF;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  rem_q,   rem_d;    // partial remainder
    logic [W-1:0]  dvd_q,   dvd_d;    // dividend shifting out / quotient bits shifting in
    logic [W-1:0]  div_q,   div_d;    // latched divisor
    logic [W-1:0]  quo_q,   quo_d;    // visible quotient
    logic [W-1:0]  res_q,   res_d;    // visible remainder
    logic          dz_q,    dz_d;

    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic          fits;
    logic [W-1:0]  rem_step;
    logic [W-1:0]  dvd_step;

    // One restoring step: W+1-bit trial keeps divisors near 2^W-1 from overflowing.
    always_comb begin
        shifted  = {rem_q, dvd_q[W-1]};
        fits     = (shifted >= {1'b0, div_q});
        trial    = shifted - {1'b0, div_q};
        rem_step = fits ? trial[W-1:0] : shifted[W-1:0];
        dvd_step = (dvd_q << 1) | W'(fits);
    end

    // Next-state and datapath control; visible results only move on completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        quo_d   = quo_q;
        res_d   = res_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    div_d = B;
                    dvd_d = A;
                    rem_d = '0;
                    cnt_d = CW'(W);
                    if (B != '0) begin
                        state_d = CALC;
                    end else begin
                        state_d = DONE;
                        quo_d   = '1;
                        res_d   = A;
                        dz_d    = 1'b1;
                    end
                end
            end
            CALC: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = dvd_step;
                    res_d   = rem_step;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == CALC);
    assign done     = (state_q == DONE);
    assign Q        = quo_q;
    assign R        = res_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: directed checks on an 8-bit divider and a randomized
// invariant sweep on a 16-bit divider.
module tb_divisor_secuencial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, busy8, done8, dz8;
    logic [7:0]  a8, b8, q8, r8;
    logic        start16, busy16, done16, dz16;
    logic [15:0] a16, b16, q16, r16;

    int tests = 0;
    int fails = 0;

    divisor_secuencial #(.SAMPLES(1), .OSF(8)) u_div8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Q(q8), .R(r8), .div_zero(dz8)
    );

    divisor_secuencial #(.SAMPLES(2), .OSF(8)) u_div16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .Q(q16), .R(r16), .div_zero(dz16)
    );

    // Called at a negedge: present a request for the next rising edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        a8 = a; b8 = b; start8 = 1'b1;
    endtask

    // Counts negedges until done is seen; lat = -1 on timeout.
    task automatic wait_done8(output int lat, output int busy_cnt);
        bit seen;
        seen = 1'b0; lat = 0; busy_cnt = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            lat++;
            if (busy8) busy_cnt++;
            if (done8) seen = 1'b1;
        end
        if (!seen) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done8); end
        tests++; if (q8 !== 8'd0) begin fails++; $display("FAIL reset_q: got %0d expected 0", q8); end
        tests++; if (r8 !== 8'd0) begin fails++; $display("FAIL reset_r: got %0d expected 0", r8); end
        tests++; if (dz8 !== 1'b0) begin fails++; $display("FAIL reset_dz: got %b expected 0", dz8); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin fails++; $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", busy8, done8); end
    endtask

    task automatic test_basic();
        int lat, bc;
        issue8(8'd200, 8'd7);
        wait_done8(lat, bc);
        tests++; if (lat !== 9) begin fails++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        tests++; if (bc !== 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
        tests++; if (q8 !== 8'd28) begin fails++; $display("FAIL basic_q: got %0d expected 28", q8); end
        tests++; if (r8 !== 8'd4) begin fails++; $display("FAIL basic_r: got %0d expected 4", r8); end
        tests++; if (dz8 !== 1'b0) begin fails++; $display("FAIL basic_dz: got %b expected 0", dz8); end
        @(negedge clk);
        tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b expected 0", done8); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        issue8(8'd5, 8'd0);
        wait_done8(lat, bc);
        tests++; if (lat !== 1) begin fails++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        tests++; if (bc !== 0) begin fails++; $display("FAIL dz_busy: got %0d expected 0", bc); end
        tests++; if (q8 !== 8'd255) begin fails++; $display("FAIL dz_q: got %0d expected 255", q8); end
        tests++; if (r8 !== 8'd5) begin fails++; $display("FAIL dz_r: got %0d expected 5", r8); end
        tests++; if (dz8 !== 1'b1) begin fails++; $display("FAIL dz_flag: got %b expected 1", dz8); end
        @(negedge clk);
        tests++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin fails++; $display("FAIL dz_after: got done=%b busy=%b expected 0/0", done8, busy8); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue8(8'd4, 8'd9);
        wait_done8(lat, bc);
        tests++; if (lat !== 9) begin fails++; $display("FAIL b2b_lat1: got %0d expected 9", lat); end
        tests++; if (q8 !== 8'd0 || r8 !== 8'd4 || dz8 !== 1'b0) begin fails++; $display("FAIL b2b_res1: got q=%0d r=%0d dz=%b expected 0/4/0", q8, r8, dz8); end
        issue8(8'd255, 8'd1);
        wait_done8(lat, bc);
        tests++; if (lat !== 9 || bc !== 8) begin fails++; $display("FAIL b2b_lat2: got lat=%0d busy=%0d expected 9/8", lat, bc); end
        tests++; if (q8 !== 8'd255 || r8 !== 8'd0) begin fails++; $display("FAIL b2b_res2: got q=%0d r=%0d expected 255/0", q8, r8); end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int lat, bc, extra;
        issue8(8'd3, 8'd3);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk); issue8(8'd1, 8'd1);
        @(negedge clk); start8 = 1'b0;
        wait_done8(lat, bc);
        tests++; if (lat !== 6) begin fails++; $display("FAIL ign_latency: got %0d expected 6", lat); end
        tests++; if (q8 !== 8'd1 || r8 !== 8'd0) begin fails++; $display("FAIL ign_res: got q=%0d r=%0d expected 1/0", q8, r8); end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL ign_extra_op: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_hold();
        int lat, bc, bad;
        bit seen;
        issue8(8'd200, 8'd7);
        wait_done8(lat, bc);
        issue8(8'd100, 8'd9);
        bad = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            if (done8) seen = 1'b1;
            else if (q8 !== 8'd28 || r8 !== 8'd4) bad++;
        end
        tests++; if (!seen || bad !== 0) begin fails++; $display("FAIL hold_outputs: got done=%b changed=%0d expected 1/0", seen, bad); end
        tests++; if (q8 !== 8'd11 || r8 !== 8'd1) begin fails++; $display("FAIL hold_res: got q=%0d r=%0d expected 11/1", q8, r8); end
        @(negedge clk);
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [8] = '{8'd0, 8'd3,   8'd173, 8'd254, 8'd255, 8'd255, 8'd255, 8'd128};
        logic [7:0] tb [8] = '{8'd5, 8'd200, 8'd1,   8'd255, 8'd255, 8'd128, 8'd254, 8'd2};
        logic [7:0] tq [8] = '{8'd0, 8'd0,   8'd173, 8'd0,   8'd1,   8'd1,   8'd1,   8'd64};
        logic [7:0] tr [8] = '{8'd0, 8'd3,   8'd0,   8'd254, 8'd0,   8'd127, 8'd1,   8'd0};
        int lat, bc;
        for (int unsigned i = 0; i < 8; i++) begin
            issue8(ta[i], tb[i]);
            wait_done8(lat, bc);
            tests++;
            if (lat !== 9 || q8 !== tq[i] || r8 !== tr[i]) begin
                fails++;
                $display("FAIL bound_%0d: got lat=%0d q=%0d r=%0d expected 9/%0d/%0d", i, lat, q8, r8, tq[i], tr[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, bc, pulses;
        issue8(8'd200, 8'd7);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin fails++; $display("FAIL abort_ctrl: got busy=%b done=%b expected 0/0", busy8, done8); end
        tests++; if (q8 !== 8'd0 || r8 !== 8'd0 || dz8 !== 1'b0) begin fails++; $display("FAIL abort_data: got q=%0d r=%0d dz=%b expected 0/0/0", q8, r8, dz8); end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done8 || busy8) pulses++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done8 || busy8) pulses++;
        tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_no_done: got %0d active cycles expected 0", pulses); end
        issue8(8'd255, 8'd16);
        wait_done8(lat, bc);
        tests++; if (lat !== 9 || q8 !== 8'd15 || r8 !== 8'd15 || dz8 !== 1'b0) begin fails++; $display("FAIL abort_restart: got lat=%0d q=%0d r=%0d dz=%b expected 9/15/15/0", lat, q8, r8, dz8); end
        @(negedge clk);
    endtask

    task automatic test_random16();
        logic [15:0] a, b;
        int lat;
        bit seen;
        int unsigned prod;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            if (i % 4 == 0)      b = 16'($urandom_range(1, 15));
            else if (i % 4 == 1) b = 16'($urandom_range(65000, 65535));
            else                 b = 16'($urandom_range(1, 65535));
            a16 = a; b16 = b; start16 = 1'b1;
            lat = 0; seen = 1'b0;
            for (int j = 0; j < 40 && !seen; j++) begin
                @(negedge clk);
                start16 = 1'b0;
                lat++;
                if (done16) seen = 1'b1;
            end
            tests++;
            if (!seen || lat !== 17) begin
                fails++;
                $display("FAIL rnd_latency_%0d: got %0d expected 17", i, seen ? lat : -1);
            end
            prod = 32'(q16) * 32'(b) + 32'(r16);
            tests++;
            if (prod !== 32'(a) || r16 >= b || q16 !== a / b || dz16 !== 1'b0) begin
                fails++;
                $display("FAIL rnd_result_%0d: A=%0d B=%0d got q=%0d r=%0d expected q=%0d r=%0d", i, a, b, q16, r16, a / b, a % b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_ignore_busy();
        test_hold();
        test_boundaries();
        test_reset_abort();
        test_random16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
